tick_pwm: RTL
=============

// Module: tick_pwm
// PURPOSE
//  Downstream consumer of the programmable delay/prescaler strobe (o_cnt).
//  Counts strobe ticks and produces a PWM waveform with programmable period and
//  duty, both measured in ticks. Period/duty are double-buffered: a new setting
//  is captured into a shadow register and applied only at a period boundary.
// PARAMETERS
//  WIDTH   4   width of period, duty and internal tick counter (max period 2^WIDTH-1)
// PORTS
//  clk           in   1      system clock, rising edge
//  i_rst         in   1      reset, asynchronous, active-high
//  i_tick        in   1      1-cycle strobe from prescaler (its o_cnt); one PWM step
//  i_enbl        in   1      1 = RUN, 0 = IDLE
//  i_period      in   WIDTH  requested period in ticks (0 = stopped)
//  i_duty        in   WIDTH  requested high time in ticks
//  i_load        in   1      1-cycle request: capture i_period/i_duty into shadow
//  o_load_pend   out  1      shadow holds a value not yet applied
//  o_pwm         out  1      PWM output
//  o_period_end  out  1      1-cycle pulse on each period wrap
// BEHAVIOUR
//  Reset (async, i_rst=1): cnt=0, state=IDLE, act_period=act_duty=0,
//   shadow=0, o_load_pend=0, o_period_end=0, o_pwm=0. Applies mid-operation.
//  Registers: cnt[WIDTH], act_period/act_duty, sh_period/sh_duty, pend, state.
//  o_pwm = (state==RUN) && (act_period!=0) && (cnt < act_duty); decoded from regs
//   only, no input-to-output combinational path.
//  States: IDLE -> RUN on clk with i_enbl=1; RUN -> IDLE on clk with i_enbl=0.
//  IDLE: cnt held 0, i_tick ignored, o_period_end=0; a pending shadow is copied
//   to active on the next clk, pend cleared.
//  RUN, on clk with i_tick=1 and act_period!=0:
//   - cnt==act_period-1: cnt<=0, o_period_end<=1 (next cycle, one cycle wide),
//     if pend then active<=shadow, pend<=0.
//   - else cnt<=cnt+1.
//  RUN with act_period==0 (stopped): cnt held 0, o_pwm=0, no period_end; pending
//   shadow applied on next clk as in IDLE.
//  i_load=1 on any clk: shadow<=i_period/i_duty, pend<=1; repeated loads
//   before a boundary overwrite shadow (last wins).
//  i_load coincident with an apply event (wrap, IDLE, stopped): i_period/i_duty
//   go straight to active, shadow updated too, pend stays 0.
//  Leaving RUN mid-period: next clk cnt=0, o_pwm=0; re-entry starts a full
//   period at cnt=0 (o_pwm high from first RUN cycle if act_duty>0).
//  Duty limits: act_duty=0 -> 0% (always low); act_duty>=act_period -> 100%.
//  act_period=1: cnt stays 0, period_end every tick.
//  cnt never exceeds act_period-1; no wrap at 2^WIDTH.
//  i_tick held high > 1 cycle counts one step per clk.
// TESTING
//  1 Assert i_rst mid-run -> o_pwm, o_period_end, o_load_pend = 0 immediately.
//  2 IDLE, load period=5 duty=2, i_enbl=1, i_tick=1 constant -> o_pwm 1,1,0,0,0
//    repeating; o_period_end once per 5 clks; o_load_pend=1 one cycle only.
//  3 period=5 duty=2, i_tick every 4th clk (prescaler module 4) -> o_pwm high
//    8 of every 20 clks.
//  4 Running 5/2, load period=3 duty=3 at cnt=1 -> o_load_pend=1 until wrap,
//    then o_pwm constant 1, pend=0.
//  5 i_load at wrap tick -> new values active next clk, o_load_pend never rises.
//  6 duty=0 -> o_pwm always 0; period=0 -> o_pwm 0, no period_end, cnt held 0.

Source files
------------

// File: rtl/tick_pwm.sv
// Tick-driven PWM generator: period and duty are counted in prescaler strobes and
// double-buffered through a shadow register that is applied only at a period boundary.
module tick_pwm #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_enbl,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_duty,
    input  logic             i_load,
    output logic             o_load_pend,
    output logic             o_pwm,
    output logic             o_period_end
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] sh_duty;
    logic             pend;
    logic             period_end;

    logic [WIDTH-1:0] last;
    logic             stopped;
    logic             step;
    logic             wrap;
    logic             apply;

    // Idle or zero-period counts as stopped: a pending shadow is applied at once there,
    // otherwise only on the wrapping tick.
    always_comb begin
        last    = act_period - 1'b1;
        stopped = (state == IDLE) || (act_period == '0);
        step    = (state == RUN) && i_enbl && (act_period != '0) && i_tick;
        wrap    = step && (cnt == last);
        apply   = wrap || (stopped && pend);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            act_period <= '0;
            act_duty   <= '0;
            sh_period  <= '0;
            sh_duty    <= '0;
            pend       <= 1'b0;
            period_end <= 1'b0;
        end else begin
            state      <= i_enbl ? RUN : IDLE;
            period_end <= wrap;

            // Leaving RUN clears the count so re-entry starts a full period.
            if ((state == IDLE) || !i_enbl || (act_period == '0)) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end

            if (i_load) begin
                sh_period <= i_period;
                sh_duty   <= i_duty;
            end

            // A load landing on an apply event bypasses the shadow.
            if (apply) begin
                pend <= 1'b0;
                if (i_load) begin
                    act_period <= i_period;
                    act_duty   <= i_duty;
                end else if (pend) begin
                    act_period <= sh_period;
                    act_duty   <= sh_duty;
                end
            end else if (i_load) begin
                pend <= 1'b1;
            end
        end
    end

    assign o_pwm        = (state == RUN) && (act_period != '0) && (cnt < act_duty);
    assign o_load_pend  = pend;
    assign o_period_end = period_end;

endmodule
